// File: rtl/pc_ras_u.sv
// rtl/pc_ras_u.sv - program counter with increment, relative add and return-address stack
module pc_ras_u #(
    parameter int             W         = 32,
    parameter int             STEP      = 4,
    parameter int             DEPTH     = 4,
    parameter logic [W-1:0]   RESET_VEC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    inout  wire  [W-1:0]               bus,
    input  logic                       PCin,
    input  logic                       PCout,
    input  logic                       PCinc,
    input  logic                       PCrel,
    input  logic                       PCpush,
    input  logic                       PCpop,
    input  logic                       err_clr,
    output logic [W-1:0]               pc_q,
    output logic [$clog2(DEPTH+1)-1:0] sp,
    output logic                       stk_full,
    output logic                       stk_empty,
    output logic                       err
);

    localparam int SPW = $clog2(DEPTH + 1);
    // RAS index width; a single-entry stack still needs one address bit
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [W-1:0]   STEP_W = W'(STEP);
    localparam logic [SPW-1:0] SP_ONE = SPW'(1);
    localparam logic [SPW-1:0] SP_MAX = SPW'(DEPTH);

    logic [W-1:0]   pc_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           err_q, err_d;
    logic [W-1:0]   ras_q [DEPTH];
    logic [W-1:0]   ras_d [DEPTH];
    logic [SPW-1:0] sp_m1;
    logic [AW-1:0]  push_idx;
    logic [AW-1:0]  top_idx;
    logic           fault;

    assign sp        = sp_q;
    assign err       = err_q;
    assign stk_full  = (sp_q == SP_MAX);
    assign stk_empty = (sp_q == '0);
    assign sp_m1     = sp_q - SP_ONE;
    assign push_idx  = sp_q[AW-1:0];
    assign top_idx   = sp_m1[AW-1:0];

    // Drive the pre-edge PC onto the shared bus only while requested and out of reset
    assign bus = (PCout && rst) ? pc_q : {W{1'bz}};

    // Select the single winning command and compute next PC, stack and error state
    always_comb begin
        pc_d  = pc_q;
        sp_d  = sp_q;
        ras_d = ras_q;
        fault = 1'b0;
        if (PCpop) begin
            if (stk_empty) begin
                fault = 1'b1;
            end else begin
                pc_d = ras_q[top_idx];
                sp_d = sp_m1;
            end
        end else if (PCpush) begin
            // A bus-reading command cannot sample the bus while we are driving it
            if (PCout || stk_full) begin
                fault = 1'b1;
            end else begin
                ras_d[push_idx] = pc_q + STEP_W;
                sp_d            = sp_q + SP_ONE;
                pc_d            = bus;
            end
        end else if (PCin) begin
            if (PCout) fault = 1'b1;
            else       pc_d  = bus;
        end else if (PCrel) begin
            if (PCout) fault = 1'b1;
            else       pc_d  = pc_q + bus;
        end else if (PCinc) begin
            pc_d = pc_q + STEP_W;
        end
        // A new fault on the same edge as a clear leaves the flag set
        err_d = fault | (err_q & ~err_clr);
    end

    // PC, stack pointer and sticky error register with asynchronous reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= RESET_VEC;
            sp_q  <= '0;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            sp_q  <= sp_d;
            err_q <= err_d;
        end
    end

    // Return-address storage; contents are meaningless after reset so no reset is applied
    always_ff @(posedge clk) begin
        ras_q <= ras_d;
    end

endmodule

// File: tb/tb_pc_ras_u.sv
// tb/tb_pc_ras_u.sv - self-checking bench for pc_ras_u against a queue-based model
module tb_pc_ras_u;

    localparam int DEPTH = 4;

    localparam int C_INC  = 1;
    localparam int C_IN   = 2;
    localparam int C_REL  = 4;
    localparam int C_PUSH = 8;
    localparam int C_POP  = 16;
    localparam int C_OUT  = 32;
    localparam int C_CLR  = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] drv;
    logic        drv_en;
    wire  [31:0] bus;
    logic        PCin, PCout, PCinc, PCrel, PCpush, PCpop, err_clr;
    logic [31:0] pc_q;
    logic [2:0]  sp;
    logic        stk_full, stk_empty, err;

    int checks   = 0;
    int failures = 0;

    // Model state
    logic [31:0] m_pc;
    logic [31:0] m_stk[$];
    logic        m_err;

    assign bus = drv_en ? drv : 32'hz;

    always #5 clk = ~clk;

    pc_ras_u #(.W(32), .STEP(4), .DEPTH(DEPTH), .RESET_VEC(32'h0)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .PCin(PCin), .PCout(PCout), .PCinc(PCinc), .PCrel(PCrel),
        .PCpush(PCpush), .PCpop(PCpop), .err_clr(err_clr),
        .pc_q(pc_q), .sp(sp), .stk_full(stk_full), .stk_empty(stk_empty), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: one command per edge, highest priority wins
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc  = 32'h0;
            m_stk.delete();
            m_err = 1'b0;
        end else begin
            logic bad;
            bad = 1'b0;
            if (PCpop) begin
                if (m_stk.size() == 0) bad = 1'b1;
                else m_pc = m_stk.pop_back();
            end else if (PCpush) begin
                if (PCout || m_stk.size() == DEPTH) bad = 1'b1;
                else begin
                    m_stk.push_back(m_pc + 32'd4);
                    m_pc = drv;
                end
            end else if (PCin) begin
                if (PCout) bad = 1'b1;
                else m_pc = drv;
            end else if (PCrel) begin
                if (PCout) bad = 1'b1;
                else m_pc = m_pc + drv;
            end else if (PCinc) begin
                m_pc = m_pc + 32'd4;
            end
            if (bad) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
        end
    end

    // Compare DUT against the model every cycle, away from the active edge
    always @(negedge clk) begin
        chk("pc", pc_q, m_pc);
        chk("sp", {29'b0, sp}, m_stk.size());
        chk("stk_full", {31'b0, stk_full}, {31'b0, m_stk.size() == DEPTH});
        chk("stk_empty", {31'b0, stk_empty}, {31'b0, m_stk.size() == 0});
        chk("err", {31'b0, err}, {31'b0, m_err});
        if (PCout && rst && !drv_en) chk("bus_drive", bus, m_pc);
    end

    task automatic cyc(input int c, input logic [31:0] d, input logic den);
        PCinc   = (c & C_INC)  != 0;
        PCin    = (c & C_IN)   != 0;
        PCrel   = (c & C_REL)  != 0;
        PCpush  = (c & C_PUSH) != 0;
        PCpop   = (c & C_POP)  != 0;
        PCout   = (c & C_OUT)  != 0;
        err_clr = (c & C_CLR)  != 0;
        drv     = d;
        drv_en  = den;
        @(posedge clk);
        #2;
    endtask

    // Pin both the model and the DUT to a hand-computed PC
    task automatic lit_pc(input string name, input logic [31:0] exp);
        chk({name, "_model"}, m_pc, exp);
        chk(name, pc_q, exp);
    endtask

    initial begin
        rst = 1'b0;
        PCin = 0; PCout = 0; PCinc = 0; PCrel = 0; PCpush = 0; PCpop = 0; err_clr = 0;
        drv = '0; drv_en = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;

        // Reset state
        chk("rst_pc", pc_q, 32'h0);
        chk("rst_sp", {29'b0, sp}, 32'd0);
        chk("rst_empty", {31'b0, stk_empty}, 32'd1);
        chk("rst_full", {31'b0, stk_full}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);

        // Load and drive
        cyc(C_IN, 32'hF, 1'b1);
        lit_pc("load", 32'hF);
        PCout = 1'b1; drv_en = 1'b0;
        #1 chk("drive_bus", bus, 32'h0000000F);
        cyc(C_OUT, 32'h0, 1'b0);
        PCout = 1'b0; drv = 32'hA5A5A5A5; drv_en = 1'b1;
        #1 chk("bus_released", bus, 32'hA5A5A5A5);
        cyc(0, 32'hA5A5A5A5, 1'b1);
        lit_pc("hold", 32'hF);

        // Increment and wrap
        cyc(C_IN, 32'hFFFFFFF8, 1'b1);
        cyc(C_INC, 32'h0, 1'b0); lit_pc("inc1", 32'hFFFFFFFC);
        cyc(C_INC, 32'h0, 1'b0); lit_pc("inc_wrap", 32'h0);
        cyc(C_INC, 32'h0, 1'b0); lit_pc("inc3", 32'h4);
        chk("inc_err", {31'b0, err}, 32'd0);

        // Relative branches
        cyc(C_IN, 32'h100, 1'b1);
        cyc(C_REL, 32'hFFFFFFF0, 1'b1); lit_pc("rel_back", 32'hF0);
        cyc(C_REL, 32'h20, 1'b1);       lit_pc("rel_fwd", 32'h110);

        // Call/return nesting to full depth and beyond
        cyc(C_IN, 32'h10, 1'b1);
        for (int i = 1; i <= 4; i++) cyc(C_PUSH, 32'h100 * i, 1'b1);
        chk("push_sp", {29'b0, sp}, 32'd4);
        chk("push_full", {31'b0, stk_full}, 32'd1);
        cyc(C_PUSH, 32'h500, 1'b1);
        lit_pc("overflow_pc", 32'h400);
        chk("overflow_err", {31'b0, err}, 32'd1);
        cyc(C_POP, 32'h0, 1'b0); lit_pc("pop1", 32'h304);
        cyc(C_POP, 32'h0, 1'b0); lit_pc("pop2", 32'h204);
        cyc(C_POP, 32'h0, 1'b0); lit_pc("pop3", 32'h104);
        cyc(C_POP, 32'h0, 1'b0); lit_pc("pop4", 32'h14);
        chk("pop_empty", {31'b0, stk_empty}, 32'd1);
        cyc(C_POP, 32'h0, 1'b0);
        lit_pc("underflow_pc", 32'h14);
        chk("underflow_err", {31'b0, err}, 32'd1);
        cyc(C_CLR, 32'h0, 1'b0);
        chk("err_clr", {31'b0, err}, 32'd0);

        // Priority and conflicts
        cyc(C_IN, 32'h40, 1'b1);
        cyc(C_PUSH, 32'h999, 1'b1);
        cyc(C_POP | C_INC, 32'h0, 1'b0); lit_pc("pop_over_inc", 32'h44);
        cyc(C_IN | C_INC, 32'h80, 1'b1); lit_pc("in_over_inc", 32'h80);
        PCin = 1'b1; PCout = 1'b1; drv_en = 1'b0;
        #1 chk("conflict_bus", bus, 32'h80);
        cyc(C_IN | C_OUT, 32'h0, 1'b0);
        lit_pc("conflict_pc", 32'h80);
        chk("conflict_err", {31'b0, err}, 32'd1);
        cyc(C_CLR | C_POP, 32'h0, 1'b0);
        chk("clr_vs_set", {31'b0, err}, 32'd1);
        cyc(C_CLR, 32'h0, 1'b0);
        cyc(C_REL | C_OUT, 32'h0, 1'b0);  lit_pc("rel_conflict", 32'h80);
        cyc(C_PUSH | C_OUT, 32'h0, 1'b0); lit_pc("push_conflict", 32'h80);
        chk("push_conflict_sp", {29'b0, sp}, 32'd0);
        cyc(C_CLR, 32'h0, 1'b0);
        cyc(C_PUSH, 32'h300, 1'b1);
        cyc(C_POP | C_OUT, 32'h0, 1'b0); lit_pc("pop_with_out", 32'h84);
        chk("pop_out_err", {31'b0, err}, 32'd0);
        cyc(C_INC | C_OUT, 32'h0, 1'b0); lit_pc("inc_with_out", 32'h88);

        // Asynchronous reset between edges
        cyc(C_PUSH, 32'h200, 1'b1);
        cyc(C_PUSH, 32'h600, 1'b1);
        cyc(C_POP | C_PUSH, 32'h0, 1'b0);
        cyc(C_IN | C_OUT, 32'h0, 1'b0);
        cyc(0, 32'h0, 1'b0);
        #1 rst = 1'b0;
        #1;
        chk("async_pc", pc_q, 32'h0);
        chk("async_sp", {29'b0, sp}, 32'd0);
        chk("async_err", {31'b0, err}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        cyc(C_INC, 32'h0, 1'b0); lit_pc("after_reset_inc", 32'h4);
        cyc(0, 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
